// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush control for the six-stage in-order core
// (IF, ID, EXE, MEM, MEM2, WB). It turns hazard, busy and exception
// indications into per-pipeline-register write enables, bubble-insert
// controls and the front-end redirect pulse. A two-state machine
// (RUN / EXC_WAIT) holds back an exception redirect until an in-flight
// I-cache refill has completed.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, adds saturating stall counters DH_Stall_Cnt and
//   Cache_Stall_Cnt (CNT_W bits each). When undefined those ports and
//   registers do not exist and the control behaviour is unchanged.
//
// Parameters:
//   CNT_W            width of the optional performance counters (>= 2)
//
// Ports:
//   clk              core clock
//   resetn           asynchronous active-low reset
//   ID_EX_DH_Stall   ID needs a load/MFC0 result still in EXE
//   ID_MEM1_DH_Stall ID needs a load/MFC0 result still in MEM
//   ID_MEM2_DH_Stall ID needs a load result still in MEM2
//   Icache_Busy      I-cache miss/refill in progress
//   Dcache_Busy      D-cache miss in MEM/MEM2, whole pipe freezes
//   Div_Busy         multi-cycle divide occupying EXE
//   Exc_Valid        exception or ERET being committed in MEM
//   IF_Wr..WB_Wr     pipeline register update enables (PC .. MEM2/WB)
//   ID/EXE/MEM_Flush named register loads a bubble (only with its _Wr)
//   Redirect_Valid   one-cycle pulse, PC loads exception vector/EPC
//   DH_Stall_Cnt     cycles spent in data-hazard stall  (perf only)
//   Cache_Stall_Cnt  cycles lost to cache stalls        (perf only)
//
// Outputs other than the counters are combinational from inputs and state.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ID_EX_DH_Stall,
    input  logic             ID_MEM1_DH_Stall,
    input  logic             ID_MEM2_DH_Stall,
    input  logic             Icache_Busy,
    input  logic             Dcache_Busy,
    input  logic             Div_Busy,
    input  logic             Exc_Valid,
    output logic             IF_Wr,
    output logic             ID_Wr,
    output logic             EXE_Wr,
    output logic             MEM_Wr,
    output logic             MEM2_Wr,
    output logic             WB_Wr,
    output logic             ID_Flush,
    output logic             EXE_Flush,
    output logic             MEM_Flush,
    output logic             Redirect_Valid
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] DH_Stall_Cnt,
    output logic [CNT_W-1:0] Cache_Stall_Cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_EXC_WAIT = 1'b1
    } state_t;

    // The counter increment below is built from a (CNT_W-1)-wide zero field.
    if (CNT_W < 2) begin : g_cnt_w_check
        $error("pipeline_ctrl: CNT_W must be at least 2");
    end

    state_t state_r;
    state_t state_nxt_s;

    logic if_wr_s;
    logic id_wr_s;
    logic exe_wr_s;
    logic mem_wr_s;
    logic mem2_wr_s;
    logic wb_wr_s;
    logic id_flush_s;
    logic exe_flush_s;
    logic mem_flush_s;
    logic redirect_s;
    logic dh_any_s;

    assign dh_any_s = ID_EX_DH_Stall | ID_MEM1_DH_Stall | ID_MEM2_DH_Stall;

    // Priority-encoded stall/flush decode and next-state selection.
    always_comb begin
        if_wr_s     = 1'b0;
        id_wr_s     = 1'b0;
        exe_wr_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem2_wr_s   = 1'b0;
        wb_wr_s     = 1'b0;
        id_flush_s  = 1'b0;
        exe_flush_s = 1'b0;
        mem_flush_s = 1'b0;
        redirect_s  = 1'b0;
        state_nxt_s = state_r;

        if (!resetn) begin
            // Everything held quiet while in reset.
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (Exc_Valid && !Dcache_Busy) begin
                        // Kill the three younger instructions, let MEM drain.
                        id_wr_s     = 1'b1;
                        exe_wr_s    = 1'b1;
                        mem_wr_s    = 1'b1;
                        id_flush_s  = 1'b1;
                        exe_flush_s = 1'b1;
                        mem_flush_s = 1'b1;
                        mem2_wr_s   = 1'b1;
                        wb_wr_s     = 1'b1;
                        if (Icache_Busy) begin
                            // PC cannot be redirected under a refill.
                            state_nxt_s = ST_EXC_WAIT;
                        end else begin
                            if_wr_s     = 1'b1;
                            redirect_s  = 1'b1;
                            state_nxt_s = ST_RUN;
                        end
                    end else if (Dcache_Busy) begin
                        // Full freeze; a pending exception waits in MEM.
                        state_nxt_s = ST_RUN;
                    end else if (Div_Busy) begin
                        mem_wr_s    = 1'b1;
                        mem_flush_s = 1'b1;
                        mem2_wr_s   = 1'b1;
                        wb_wr_s     = 1'b1;
                    end else if (dh_any_s) begin
                        exe_wr_s    = 1'b1;
                        exe_flush_s = 1'b1;
                        mem_wr_s    = 1'b1;
                        mem2_wr_s   = 1'b1;
                        wb_wr_s     = 1'b1;
                    end else if (Icache_Busy) begin
                        id_wr_s     = 1'b1;
                        id_flush_s  = 1'b1;
                        exe_wr_s    = 1'b1;
                        mem_wr_s    = 1'b1;
                        mem2_wr_s   = 1'b1;
                        wb_wr_s     = 1'b1;
                    end else begin
                        if_wr_s     = 1'b1;
                        id_wr_s     = 1'b1;
                        exe_wr_s    = 1'b1;
                        mem_wr_s    = 1'b1;
                        mem2_wr_s   = 1'b1;
                        wb_wr_s     = 1'b1;
                    end
                end

                ST_EXC_WAIT: begin
                    if (Dcache_Busy) begin
                        // Should not happen here; freeze and keep waiting.
                        state_nxt_s = ST_EXC_WAIT;
                    end else begin
                        // Keep pumping bubbles until the refill finishes.
                        id_wr_s     = 1'b1;
                        exe_wr_s    = 1'b1;
                        mem_wr_s    = 1'b1;
                        id_flush_s  = 1'b1;
                        exe_flush_s = 1'b1;
                        mem_flush_s = 1'b1;
                        mem2_wr_s   = 1'b1;
                        wb_wr_s     = 1'b1;
                        if (!Icache_Busy) begin
                            if_wr_s     = 1'b1;
                            redirect_s  = 1'b1;
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_EXC_WAIT;
                        end
                    end
                end

                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign IF_Wr          = if_wr_s;
    assign ID_Wr          = id_wr_s;
    assign EXE_Wr         = exe_wr_s;
    assign MEM_Wr         = mem_wr_s;
    assign MEM2_Wr        = mem2_wr_s;
    assign WB_Wr          = wb_wr_s;
    assign ID_Flush       = id_flush_s;
    assign EXE_Flush      = exe_flush_s;
    assign MEM_Flush      = mem_flush_s;
    assign Redirect_Valid = redirect_s;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             dh_sel_s;
    logic             cache_sel_s;
    logic [CNT_W-1:0] dh_cnt_r;
    logic [CNT_W-1:0] cache_cnt_r;

    // The flush pattern identifies the selected rule uniquely:
    // only the data-hazard rule bubbles EXE without bubbling ID, only the
    // I-cache rule bubbles ID without EXE, and only a D-cache freeze (out of
    // reset) leaves WB_Wr low.
    assign dh_sel_s    = exe_flush_s & ~id_flush_s;
    assign cache_sel_s = (state_r == ST_EXC_WAIT)
                       | (id_flush_s & ~exe_flush_s)
                       | (resetn & ~wb_wr_s);

    // Saturating stall-cycle counters, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dh_cnt_r    <= {CNT_W{1'b0}};
            cache_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (dh_sel_s && (dh_cnt_r != CNT_MAX)) begin
                dh_cnt_r <= dh_cnt_r + CNT_ONE;
            end else begin
                dh_cnt_r <= dh_cnt_r;
            end
            if (cache_sel_s && (cache_cnt_r != CNT_MAX)) begin
                cache_cnt_r <= cache_cnt_r + CNT_ONE;
            end else begin
                cache_cnt_r <= cache_cnt_r;
            end
        end
    end

    assign DH_Stall_Cnt    = dh_cnt_r;
    assign Cache_Stall_Cnt = cache_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Scenario-driven bench for pipeline_ctrl. Each step drives one input
// pattern, pushes the expected output vector into a scoreboard queue, then
// pops and compares it mid-cycle. Output vector bit order:
//   {IF_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr,
//    ID_Flush, EXE_Flush, MEM_Flush, Redirect_Valid}
// Input pattern bit order:
//   {Exc_Valid, Dcache_Busy, Div_Busy, Icache_Busy,
//    ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall}
// Each table entry is {inputs[6:0], expected[9:0], inc[1:0]} where inc
// says which counters ({dh, cache}) advance on that cycle.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int TB_CNT_W = 4;

    localparam logic [6:0] I_IDLE = 7'b0000000;
    localparam logic [6:0] I_EXC  = 7'b1000000;
    localparam logic [6:0] I_DC   = 7'b0100000;
    localparam logic [6:0] I_DIV  = 7'b0010000;
    localparam logic [6:0] I_IC   = 7'b0001000;
    localparam logic [6:0] I_DH0  = 7'b0000100;
    localparam logic [6:0] I_DH1  = 7'b0000010;
    localparam logic [6:0] I_DH2  = 7'b0000001;

    localparam logic [9:0] O_ZERO     = 10'b000000_000_0;
    localparam logic [9:0] O_RUN      = 10'b111111_000_0;
    localparam logic [9:0] O_DIV      = 10'b000111_001_0;
    localparam logic [9:0] O_DH       = 10'b001111_010_0;
    localparam logic [9:0] O_IC       = 10'b011111_100_0;
    localparam logic [9:0] O_EXC_RED  = 10'b111111_111_1;
    localparam logic [9:0] O_EXC_HOLD = 10'b011111_111_0;

    logic clk;
    logic resetn;
    logic id_ex_dh, id_mem1_dh, id_mem2_dh;
    logic icache_busy, dcache_busy, div_busy, exc_valid;
    logic if_wr, id_wr, exe_wr, mem_wr, mem2_wr, wb_wr;
    logic id_flush, exe_flush, mem_flush, redirect_valid;
`ifdef PIPE_CTRL_PERF_EN
    logic [TB_CNT_W-1:0] dh_cnt, cache_cnt;
`endif
    logic [9:0] out_vec;

    logic [9:0] sb[$];
    int nvec = 0;
    int nerr = 0;
    logic [TB_CNT_W-1:0] exp_dh = '0;
    logic [TB_CNT_W-1:0] exp_cache = '0;

    pipeline_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ID_EX_DH_Stall   (id_ex_dh),
        .ID_MEM1_DH_Stall (id_mem1_dh),
        .ID_MEM2_DH_Stall (id_mem2_dh),
        .Icache_Busy      (icache_busy),
        .Dcache_Busy      (dcache_busy),
        .Div_Busy         (div_busy),
        .Exc_Valid        (exc_valid),
        .IF_Wr            (if_wr),
        .ID_Wr            (id_wr),
        .EXE_Wr           (exe_wr),
        .MEM_Wr           (mem_wr),
        .MEM2_Wr          (mem2_wr),
        .WB_Wr            (wb_wr),
        .ID_Flush         (id_flush),
        .EXE_Flush        (exe_flush),
        .MEM_Flush        (mem_flush),
        .Redirect_Valid   (redirect_valid)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .DH_Stall_Cnt     (dh_cnt),
        .Cache_Stall_Cnt  (cache_cnt)
`endif
    );

    assign out_vec = {if_wr, id_wr, exe_wr, mem_wr, mem2_wr, wb_wr,
                      id_flush, exe_flush, mem_flush, redirect_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TB_CNT_W-1:0] sat_inc(input logic [TB_CNT_W-1:0] v, input logic en);
        if (en && (v != {TB_CNT_W{1'b1}})) return v + 1'b1;
        return v;
    endfunction

    // Drive one input pattern and queue what the DUT should answer.
    task automatic drive(input logic [6:0] in_v, input logic [9:0] exp_v);
        {exc_valid, dcache_busy, div_busy, icache_busy,
         id_ex_dh, id_mem1_dh, id_mem2_dh} = in_v;
        sb.push_back(exp_v);
    endtask

    task automatic test_reset();
        logic [18:0] st[$];
        logic [9:0]  exp;
        st = '{{I_EXC | I_IC, O_ZERO, 2'b00},
               {I_IDLE,       O_ZERO, 2'b00},
               {I_DH0 | I_DC, O_ZERO, 2'b00}};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL reset step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
        end
`ifdef PIPE_CTRL_PERF_EN
        nvec++;
        if (dh_cnt !== exp_dh || cache_cnt !== exp_cache) begin
            nerr++;
            $display("FAIL reset_cnt: got dh=%0d cache=%0d want dh=%0d cache=%0d", dh_cnt, cache_cnt, exp_dh, exp_cache);
        end
`endif
        resetn = 1'b1;
    endtask

    task automatic test_dh_stall();
        logic [18:0] st[$];
        logic [9:0]  exp;
        st = '{{I_DH0,        O_DH,  2'b10},
               {I_DH0,        O_DH,  2'b10},
               {I_IDLE,       O_RUN, 2'b00},
               {I_DH1,        O_DH,  2'b10},
               {I_DH2,        O_DH,  2'b10},
               {I_DH0 | I_IC, O_DH,  2'b10},
               {I_IC,         O_IC,  2'b01}};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL dh_stall step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
            exp_dh    = sat_inc(exp_dh, st[i][1]);
            exp_cache = sat_inc(exp_cache, st[i][0]);
        end
`ifdef PIPE_CTRL_PERF_EN
        nvec++;
        if (dh_cnt !== exp_dh || cache_cnt !== exp_cache) begin
            nerr++;
            $display("FAIL dh_stall_cnt: got dh=%0d cache=%0d want dh=%0d cache=%0d", dh_cnt, cache_cnt, exp_dh, exp_cache);
        end
`endif
    endtask

    task automatic test_dcache_freeze();
        logic [18:0] st[$];
        logic [9:0]  exp;
        st = '{{I_DC | I_DH1,         O_FREEZE_C(), 2'b01},
               {I_DC | I_DH1,         O_ZERO,       2'b01},
               {I_DC | I_DH1,         O_ZERO,       2'b01},
               {I_DC | I_EXC,         O_ZERO,       2'b01},
               {I_DC | I_DIV | I_IC,  O_ZERO,       2'b01},
               {I_IDLE,               O_RUN,        2'b00}};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL dcache_freeze step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
            exp_dh    = sat_inc(exp_dh, st[i][1]);
            exp_cache = sat_inc(exp_cache, st[i][0]);
        end
`ifdef PIPE_CTRL_PERF_EN
        nvec++;
        if (dh_cnt !== exp_dh || cache_cnt !== exp_cache) begin
            nerr++;
            $display("FAIL dcache_cnt: got dh=%0d cache=%0d want dh=%0d cache=%0d", dh_cnt, cache_cnt, exp_dh, exp_cache);
        end
`endif
    endtask

    // A full freeze is simply every enable low.
    function automatic logic [9:0] O_FREEZE_C();
        return O_ZERO;
    endfunction

    task automatic test_div();
        logic [18:0] st[$];
        logic [9:0]  exp;
        st = '{{I_DIV | I_IC,  O_DIV, 2'b00},
               {I_DIV | I_DH0, O_DIV, 2'b00},
               {I_DIV,         O_DIV, 2'b00},
               {I_IDLE,        O_RUN, 2'b00}};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL div step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
            exp_dh    = sat_inc(exp_dh, st[i][1]);
            exp_cache = sat_inc(exp_cache, st[i][0]);
        end
    endtask

    task automatic test_exc_idle();
        logic [18:0] st[$];
        logic [9:0]  exp;
        // The I_IC step after the exception proves the state stayed RUN.
        st = '{{I_EXC,                 O_EXC_RED, 2'b00},
               {I_IC,                  O_IC,      2'b01},
               {I_EXC | I_DIV | I_DH0, O_EXC_RED, 2'b00},
               {I_IDLE,                O_RUN,     2'b00}};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL exc_idle step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
            exp_dh    = sat_inc(exp_dh, st[i][1]);
            exp_cache = sat_inc(exp_cache, st[i][0]);
        end
    endtask

    task automatic test_exc_wait();
        logic [18:0] st[$];
        logic [9:0]  exp;
        st = '{{I_EXC | I_IC,         O_EXC_HOLD, 2'b00},
               {I_IC,                 O_EXC_HOLD, 2'b01},
               {I_IC | I_EXC,         O_EXC_HOLD, 2'b01},
               {I_IC | I_DH0 | I_DIV, O_EXC_HOLD, 2'b01},
               {I_DC | I_IC,          O_ZERO,     2'b01},
               {I_IC,                 O_EXC_HOLD, 2'b01},
               {I_IDLE,               O_EXC_RED,  2'b01},
               {I_IC,                 O_IC,       2'b01},
               {I_IDLE,               O_RUN,      2'b00}};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL exc_wait step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
            exp_dh    = sat_inc(exp_dh, st[i][1]);
            exp_cache = sat_inc(exp_cache, st[i][0]);
        end
`ifdef PIPE_CTRL_PERF_EN
        nvec++;
        if (dh_cnt !== exp_dh || cache_cnt !== exp_cache) begin
            nerr++;
            $display("FAIL exc_wait_cnt: got dh=%0d cache=%0d want dh=%0d cache=%0d", dh_cnt, cache_cnt, exp_dh, exp_cache);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [18:0] st[$];
        logic [9:0]  exp;
        st = '{{I_EXC,        O_EXC_RED,  2'b00},
               {I_EXC | I_IC, O_EXC_HOLD, 2'b00},
               {I_IDLE,       O_EXC_RED,  2'b01},
               {I_EXC,        O_EXC_RED,  2'b00},
               {I_IDLE,       O_RUN,      2'b00}};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL back_to_back step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
            exp_dh    = sat_inc(exp_dh, st[i][1]);
            exp_cache = sat_inc(exp_cache, st[i][0]);
        end
    endtask

    task automatic test_saturate();
        logic [18:0] st[$];
        logic [9:0]  exp;
        for (int k = 0; k < 20; k++) st.push_back({I_DH0, O_DH, 2'b10});
        st.push_back({I_IC, O_IC, 2'b01});
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i][18:12], st[i][11:2]);
            #2;
            exp = sb.pop_front();
            nvec++;
            if (out_vec !== exp) begin
                nerr++;
                $display("FAIL saturate step %0d: got %b want %b", i, out_vec, exp);
            end
            @(negedge clk);
            exp_dh    = sat_inc(exp_dh, st[i][1]);
            exp_cache = sat_inc(exp_cache, st[i][0]);
        end
`ifdef PIPE_CTRL_PERF_EN
        nvec++;
        if (dh_cnt !== exp_dh || cache_cnt !== exp_cache) begin
            nerr++;
            $display("FAIL saturate_cnt: got dh=%0d cache=%0d want dh=%0d cache=%0d", dh_cnt, cache_cnt, exp_dh, exp_cache);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [9:0] exp;
        // Enter EXC_WAIT.
        drive(I_EXC | I_IC, O_EXC_HOLD);
        #2;
        exp = sb.pop_front();
        nvec++;
        if (out_vec !== exp) begin
            nerr++;
            $display("FAIL rst_wait_enter: got %b want %b", out_vec, exp);
        end
        @(negedge clk);
        // In EXC_WAIT, Icache idle would redirect; reset must silence it.
        resetn = 1'b0;
        drive(I_IDLE, O_ZERO);
        #2;
        exp = sb.pop_front();
        nvec++;
        if (out_vec !== exp) begin
            nerr++;
            $display("FAIL rst_wait_outputs: got %b want %b", out_vec, exp);
        end
        exp_dh    = '0;
        exp_cache = '0;
`ifdef PIPE_CTRL_PERF_EN
        nvec++;
        if (dh_cnt !== exp_dh || cache_cnt !== exp_cache) begin
            nerr++;
            $display("FAIL rst_wait_cnt: got dh=%0d cache=%0d want 0", dh_cnt, cache_cnt);
        end
`endif
        @(negedge clk);
        resetn = 1'b1;
        // Back in RUN: I-cache busy alone is rule 5, not an EXC_WAIT hold.
        drive(I_IC, O_IC);
        #2;
        exp = sb.pop_front();
        nvec++;
        if (out_vec !== exp) begin
            nerr++;
            $display("FAIL rst_wait_state: got %b want %b", out_vec, exp);
        end
`ifdef PIPE_CTRL_PERF_EN
        nvec++;
        if (dh_cnt !== exp_dh || cache_cnt !== exp_cache) begin
            nerr++;
            $display("FAIL rst_release_cnt: got dh=%0d cache=%0d want 0", dh_cnt, cache_cnt);
        end
`endif
        @(negedge clk);
        drive(I_IDLE, O_RUN);
        #2;
        exp = sb.pop_front();
        nvec++;
        if (out_vec !== exp) begin
            nerr++;
            $display("FAIL rst_wait_run: got %b want %b", out_vec, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        {exc_valid, dcache_busy, div_busy, icache_busy,
         id_ex_dh, id_mem1_dh, id_mem2_dh} = 7'b0;
        @(negedge clk);
        test_reset();
        test_dh_stall();
        test_dcache_freeze();
        test_div();
        test_exc_idle();
        test_exc_wait();
        test_back_to_back();
        test_saturate();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
